// File: rtl/mlp_train_sequencer_pkg.sv
// Shared fixed-point types, state encoding and threshold helpers used by the
// training sequencer and the MLP core.
package Common;
  localparam int SFP_W    = 16;
  localparam int SFP_FRAC = 8;

  typedef logic signed [SFP_W-1:0] sfp;

  localparam sfp ONE  = sfp'(1 << SFP_FRAC);
  localparam sfp HALF = sfp'(1 << (SFP_FRAC - 1));

  typedef enum logic [2:0] {
    IDLE, TR_ISSUE, TR_WAIT, EPOCH_END, INF_ISSUE, INF_WAIT
  } state_t;

  // Signed compare so negative activations never read as logic 1.
  function automatic logic above_half(sfp x);
    return x > HALF;
  endfunction

  function automatic sfp bit_to_sfp(logic b);
    return b ? ONE : '0;
  endfunction
endpackage

// File: rtl/mlp_train_sequencer_bit_sync.sv
// Multi-flop synchroniser for asynchronous level inputs, one chain per bit.
module bit_sync #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [DEPTH-1:0][WIDTH-1:0] sync_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_pipe <= '0;
    end else begin
      sync_pipe[0] <= d;
      for (int s = 1; s < DEPTH; s++) sync_pipe[s] <= sync_pipe[s-1];
    end
  end

  assign q = sync_pipe[DEPTH-1];
endmodule

// File: rtl/mlp_train_sequencer.sv
// Drives an MLP core through training epochs over a fixed sample table, then
// streams synchronised pin values through it for continuous inference.
module mlp_train_sequencer import Common::*; #(
  parameter int INPUTS      = 2,
  parameter int OUTPUTS     = 1,
  parameter int SAMPLES     = 4,
  parameter int MAX_EPOCHS  = 10,
  parameter logic [SAMPLES*INPUTS-1:0]  SAMPLE_IN  = 8'b11_10_01_00,
  parameter logic [SAMPLES*OUTPUTS-1:0] SAMPLE_EXP = 4'b1000,
  parameter int EARLY_STOP  = 1,
  parameter int SYNC_STAGES = 2,
  localparam int EW = $clog2(MAX_EPOCHS + 1),
  localparam int CW = $clog2(SAMPLES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [INPUTS-1:0]      pins,
  output logic                   core_valid,
  input  logic                   core_ready,
  output sfp   [INPUTS-1:0]      core_values,
  output sfp   [OUTPUTS-1:0]     core_expected,
  output logic                   core_training,
  input  logic                   core_done,
  input  sfp   [OUTPUTS-1:0]     core_prediction,
  output logic [OUTPUTS-1:0]     pred_bits,
  output logic                   busy,
  output logic                   trained,
  output logic [EW-1:0]          epoch,
  output logic [CW-1:0]          epoch_correct
);
  localparam int IW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

  state_t            state, state_nxt;
  logic [IW-1:0]     idx;
  logic [CW-1:0]     run_correct;
  logic              retrain_pend;
  sfp [INPUTS-1:0]   inf_vals;
  logic [INPUTS-1:0] pins_s;
  logic [INPUTS-1:0] in_row;
  logic [OUTPUTS-1:0] exp_row, hit, out_ok;
  logic [EW-1:0]     epoch_nxt;
  logic              last, stop, retrain;

  bit_sync #(.WIDTH(INPUTS), .DEPTH(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pins),
    .q   (pins_s)
  );

  assign in_row  = INPUTS'(SAMPLE_IN >> (int'(idx) * INPUTS));
  assign exp_row = OUTPUTS'(SAMPLE_EXP >> (int'(idx) * OUTPUTS));

  // Per-output threshold lanes; a sample scores only if every lane agrees.
  for (genvar j = 0; j < OUTPUTS; j++) begin : g_out
    assign hit[j]    = above_half(core_prediction[j]);
    assign out_ok[j] = (hit[j] == exp_row[j]);
  end

  assign last      = (idx == IW'(SAMPLES - 1));
  assign epoch_nxt = epoch + EW'(1);
  assign stop      = (epoch_nxt == EW'(MAX_EPOCHS)) ||
                     ((EARLY_STOP != 0) && (run_correct == CW'(SAMPLES)));
  assign retrain   = retrain_pend | start;

  always_comb begin
    state_nxt     = state;
    core_valid    = 1'b0;
    core_training = 1'b0;
    busy          = 1'b0;
    core_values   = '0;
    core_expected = '0;
    unique case (state)
      IDLE:      if (start) state_nxt = TR_ISSUE;
      TR_ISSUE: begin
        core_valid = 1'b1;
        if (core_ready) state_nxt = TR_WAIT;
      end
      TR_WAIT:   if (core_done) state_nxt = last ? EPOCH_END : TR_ISSUE;
      EPOCH_END: state_nxt = stop ? INF_ISSUE : TR_ISSUE;
      INF_ISSUE: begin
        core_valid = 1'b1;
        if (core_ready) state_nxt = INF_WAIT;
      end
      INF_WAIT:  if (core_done) state_nxt = retrain ? TR_ISSUE : INF_ISSUE;
      default:   state_nxt = IDLE;
    endcase
    if (state inside {TR_ISSUE, TR_WAIT, EPOCH_END}) begin
      busy          = 1'b1;
      core_training = 1'b1;
      for (int i = 0; i < INPUTS; i++)  core_values[i]   = bit_to_sfp(in_row[i]);
      for (int j = 0; j < OUTPUTS; j++) core_expected[j] = bit_to_sfp(exp_row[j]);
    end else if (state inside {INF_ISSUE, INF_WAIT}) begin
      core_values = inf_vals;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      run_correct   <= '0;
      retrain_pend  <= 1'b0;
      inf_vals      <= '0;
      pred_bits     <= '0;
      trained       <= 1'b0;
      epoch         <= '0;
      epoch_correct <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (start) begin
          epoch       <= '0;
          idx         <= '0;
          run_correct <= '0;
        end
        TR_WAIT: if (core_done) begin
          if (&out_ok) run_correct <= run_correct + CW'(1);
          if (!last) idx <= idx + IW'(1);
        end
        EPOCH_END: begin
          epoch         <= epoch_nxt;
          epoch_correct <= run_correct;
          run_correct   <= '0;
          idx           <= '0;
          if (stop) trained <= 1'b1;
        end
        INF_ISSUE: if (start) retrain_pend <= 1'b1;
        INF_WAIT: begin
          if (core_done) begin
            pred_bits <= hit;
            if (retrain) begin
              retrain_pend <= 1'b0;
              epoch        <= '0;
              idx          <= '0;
              run_correct  <= '0;
            end
          end else if (start) begin
            retrain_pend <= 1'b1;
          end
        end
        default: ;
      endcase
      // Snapshot pins on entry so the offered vector holds until accepted.
      if (state_nxt == INF_ISSUE && state != INF_ISSUE)
        for (int i = 0; i < INPUTS; i++) inf_vals[i] <= bit_to_sfp(pins_s[i]);
    end
  end
endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Directed bench: a scripted core model answers each sample; expected values
// come from the AND truth table and hand-derived cycle timing.
module tb_mlp_train_sequencer;
  import Common::*;

  typedef sfp [1:0] vec2_t;

  logic        clk = 1'b0;
  logic        rst, start, core_ready, core_done;
  logic [1:0]  pins;
  logic        core_valid, core_training, busy, trained;
  vec2_t       core_values;
  sfp [0:0]    core_expected, core_prediction;
  logic [0:0]  pred_bits;
  logic [3:0]  epoch;
  logic [2:0]  epoch_correct;

  int checks = 0;
  int errors = 0;

  localparam sfp P09 = sfp'(230);
  localparam sfp P01 = sfp'(26);

  mlp_train_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .pins(pins),
    .core_valid(core_valid), .core_ready(core_ready),
    .core_values(core_values), .core_expected(core_expected),
    .core_training(core_training), .core_done(core_done),
    .core_prediction(core_prediction), .pred_bits(pred_bits),
    .busy(busy), .trained(trained), .epoch(epoch), .epoch_correct(epoch_correct)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic vec2_t vals_of(logic [1:0] b);
    vec2_t v;
    v[0] = b[0] ? ONE : sfp'(0);
    v[1] = b[1] ? ONE : sfp'(0);
    return v;
  endfunction

  // Model core answer for training sample k: right or deliberately wrong.
  function automatic sfp answer(int k, bit right);
    bit e;
    e = (k == 3);
    return ((e ^ !right) != 0) ? ONE : sfp'(0);
  endfunction

  task automatic wait_valid();
    int n;
    n = 0;
    while (core_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (core_valid !== 1'b1) begin
      errors++; $display("FAIL wait_valid timeout core_valid=%b want 1", core_valid);
    end
  endtask

  task automatic do_xfer();
    core_ready = 1'b1; tick(); core_ready = 1'b0;
  endtask

  task automatic do_done(input sfp p);
    core_done = 1'b1; core_prediction[0] = p; tick();
    core_done = 1'b0; core_prediction[0] = '0;
  endtask

  task automatic serve(input sfp p);
    wait_valid(); do_xfer(); do_done(p);
  endtask

  task automatic run_epoch(input int ep, input bit right);
    for (int k = 0; k < 4; k++) serve(answer(k, right));
    tick();
    checks++;
    if (epoch !== 4'(ep)) begin
      errors++; $display("FAIL run_epoch epoch got %0d want %0d", epoch, ep);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; core_ready = 0; core_done = 0; pins = 2'b00;
    core_prediction[0] = '0;
    repeat (2) tick();
    rst = 1'b0; tick();
    checks++;
    if ({busy, trained, core_valid, pred_bits, epoch, epoch_correct} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b trained=%b valid=%b pred=%b ep=%0d ec=%0d want all 0",
               busy, trained, core_valid, pred_bits, epoch, epoch_correct);
    end
  endtask

  task automatic test_done_in_idle();
    core_done = 1'b1; core_prediction[0] = ONE; tick(); core_done = 1'b0;
    tick();
    checks++;
    if ({busy, core_valid, trained, epoch} !== '0) begin
      errors++; $display("FAIL idle_done got busy=%b valid=%b trained=%b ep=%0d want 0",
                         busy, core_valid, trained, epoch);
    end
  endtask

  task automatic test_train_early_stop();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({busy, core_valid, core_training, epoch} !== {3'b111, 4'd0}) begin
      errors++; $display("FAIL start_state got busy=%b valid=%b train=%b ep=%0d want 1 1 1 0",
                         busy, core_valid, core_training, epoch);
    end
    for (int ep = 1; ep <= 3; ep++) begin
      for (int k = 0; k < 4; k++) begin
        bit right;
        wait_valid();
        checks++;
        if (core_values !== vals_of(2'(k)) || core_expected[0] !== ((k == 3) ? ONE : sfp'(0))) begin
          errors++; $display("FAIL sample_data ep%0d k%0d got vals=%h exp=%h want vals=%h", ep, k,
                             core_values, core_expected[0], vals_of(2'(k)));
        end
        if (ep == 1 && k == 0) begin
          core_ready = 1'b1; core_done = 1'b1; core_prediction[0] = answer(0, 1);
          tick(); core_ready = 1'b0; core_done = 1'b0;
          checks++;
          if (core_valid !== 1'b0) begin
            errors++; $display("FAIL done_on_xfer core_valid got %b want 0", core_valid);
          end
        end else if (ep == 1 && k == 2) begin
          core_ready = 1'b1; start = 1'b1; tick(); core_ready = 1'b0; start = 1'b0;
        end else begin
          do_xfer();
        end
        right = (ep == 3) || (ep == 2 && k < 2);
        do_done(answer(k, right));
      end
      tick();
      checks++;
      if (epoch !== 4'(ep) || epoch_correct !== ((ep == 1) ? 3'd0 : (ep == 2) ? 3'd2 : 3'd4)) begin
        errors++; $display("FAIL epoch_end ep%0d got epoch=%0d ec=%0d", ep, epoch, epoch_correct);
      end
      checks++;
      if (ep < 3 && {busy, trained} !== 2'b10) begin
        errors++; $display("FAIL mid_train ep%0d got busy=%b trained=%b want 1 0", ep, busy, trained);
      end
    end
    checks++;
    if ({busy, trained, core_valid, core_training} !== 4'b0110) begin
      errors++; $display("FAIL trained_state got busy=%b trained=%b valid=%b train=%b want 0 1 1 0",
                         busy, trained, core_valid, core_training);
    end
  endtask

  task automatic test_inference();
    pins = 2'b11;
    repeat (3) tick();
    serve(P01);
    checks++;
    if (pred_bits !== 1'b0) begin
      errors++; $display("FAIL inf_first pred got %b want 0", pred_bits);
    end
    checks++;
    if (core_values !== vals_of(2'b11)) begin
      errors++; $display("FAIL inf_vals_11 got %h want %h", core_values, vals_of(2'b11));
    end
    serve(P09);
    checks++;
    if (pred_bits !== 1'b1) begin
      errors++; $display("FAIL inf_pred_11 got %b want 1", pred_bits);
    end
  endtask

  task automatic test_ready_stall();
    int bad;
    pins = 2'b01;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (core_valid !== 1'b1 || core_values !== vals_of(2'b11)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_hold got %0d unstable cycles want 0", bad);
    end
    core_ready = 1'b1;
    tick();
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      if (core_valid !== 1'b0) bad++;
      tick();
    end
    core_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL single_xfer got %0d extra valid cycles want 0", bad);
    end
    do_done(P09);
    checks++;
    if (core_values !== vals_of(2'b01)) begin
      errors++; $display("FAIL inf_vals_01 got %h want %h", core_values, vals_of(2'b01));
    end
    serve(P01);
    checks++;
    if (pred_bits !== 1'b0) begin
      errors++; $display("FAIL inf_pred_01 got %b want 0", pred_bits);
    end
    serve(P09);
  endtask

  task automatic test_retrain_max_epochs();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({busy, core_valid} !== 2'b01) begin
      errors++; $display("FAIL start_in_inf got busy=%b valid=%b want 0 1", busy, core_valid);
    end
    serve(P09);
    checks++;
    if ({busy, core_training, epoch, pred_bits} !== {2'b11, 4'd0, 1'b1}) begin
      errors++; $display("FAIL retrain_begin got busy=%b train=%b ep=%0d pred=%b want 1 1 0 1",
                         busy, core_training, epoch, pred_bits);
    end
    for (int ep = 1; ep <= 10; ep++) begin
      run_epoch(ep, 1'b0);
      if (ep == 9) begin
        checks++;
        if ({busy, pred_bits} !== 2'b11) begin
          errors++; $display("FAIL retrain_ep9 got busy=%b pred=%b want 1 1", busy, pred_bits);
        end
      end
    end
    checks++;
    if ({busy, trained, epoch_correct} !== {2'b01, 3'd0}) begin
      errors++; $display("FAIL max_epochs got busy=%b trained=%b ec=%0d want 0 1 0",
                         busy, trained, epoch_correct);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; tick(); start = 1'b0;
    serve(P09);
    run_epoch(1, 1'b0);
    serve(answer(0, 1));
    rst = 1'b1; #1;
    checks++;
    if ({busy, trained, core_valid, pred_bits, epoch, epoch_correct} !== '0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b trained=%b valid=%b pred=%b ep=%0d ec=%0d want all 0",
               busy, trained, core_valid, pred_bits, epoch, epoch_correct);
    end
    repeat (2) tick();
    rst = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({busy, trained, epoch} !== {2'b10, 4'd0}) begin
      errors++; $display("FAIL restart got busy=%b trained=%b ep=%0d want 1 0 0", busy, trained, epoch);
    end
    serve(answer(0, 1));
    checks++;
    if (core_values !== vals_of(2'b01)) begin
      errors++; $display("FAIL restart_idx got %h want %h", core_values, vals_of(2'b01));
    end
  endtask

  initial begin
    test_reset();
    test_done_in_idle();
    test_train_early_stop();
    test_inference();
    test_ready_stall();
    test_retrain_max_epochs();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
